// File: rtl/pe_node_controller.sv
// PE node controller: input FIFO, CONFIG/READ/CALC packet handling and the per-layer broadcast/compute FSM.
// Build option: define PE_NODE_READ_EN to enable the READ response path.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef TOT_FIFO_DEPTH
`define TOT_FIFO_DEPTH 4
`endif
`ifndef PeLayerNoBus
`define PeLayerNoBus 3:0
`endif

module pe_node_controller #(
    parameter int PE_ID      = 0,
    parameter int FIFO_DEPTH = `TOT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_data_valid,
    input  logic [`ROUTER_WIDTH-1:0] in_data,
    output logic                     upstream_credit,
    output logic                     out_data_valid,
    output logic [`ROUTER_WIDTH-1:0] out_data,
    input  logic                     downstream_credit,
    output logic                     rf_wr_en,
    output logic [9:0]               rf_wr_addr,
    output logic [15:0]              rf_wr_data,
    output logic                     rf_rd_en,
    output logic [9:0]               rf_rd_addr,
    input  logic [15:0]              rf_rd_data,
    output logic                     bcast_start,
    input  logic                     bcast_done,
    output logic                     comp_start,
    output logic [`PeLayerNoBus]     comp_layer,
    input  logic                     comp_done,
    output logic                     done
);
    localparam int RW    = `ROUTER_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [3:0] INFO_CONFIG   = 4'd1;
    localparam logic [3:0] INFO_READ     = 4'd2;
    localparam logic [3:0] INFO_CALC     = 4'd3;
    localparam logic [3:0] INFO_FIN_BC   = 4'd4;
    localparam logic [3:0] INFO_FIN_COMP = 4'd5;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BCAST   = 3'd1;
    localparam logic [2:0] S_SEND_FB = 3'd2;
    localparam logic [2:0] S_WAIT_FB = 3'd3;
    localparam logic [2:0] S_COMP    = 3'd4;
    localparam logic [2:0] S_SEND_FC = 3'd5;
    localparam logic [2:0] S_WAIT_FC = 3'd6;

    logic [2:0]          state;
    logic [`PeLayerNoBus] layer_no, layer_idx, last_idx;
    localparam int LNW = $bits(layer_no);

    // ---------------- input FIFO ----------------
    logic [RW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty, fifo_full, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign push       = in_data_valid && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    logic [RW-1:0] head;
    logic [3:0]    head_info;
    logic [15:0]   head_addr, head_data;
    logic          for_me, addr_zero;

    assign head      = fifo_mem[rd_ptr];
    assign head_info = head[35:32];
    assign head_addr = head[31:16];
    assign head_data = head[15:0];
    assign for_me    = (head_addr[15:10] == 6'(PE_ID));
    assign addr_zero = (head_addr == '0);

    // ---------------- output credit and send arbitration ----------------
    logic [CNT_W-1:0] out_credit;
    logic             has_credit, fin_pending, fin_send, resp_send;
    logic             resp_valid;
    logic [15:0]      resp_addr, resp_data;

    assign has_credit  = (out_credit != '0);
    assign fin_pending = (state == S_SEND_FB) || (state == S_SEND_FC);
    assign fin_send    = fin_pending && has_credit;
    assign resp_send   = resp_valid && has_credit && !fin_pending;

    assign out_data_valid = fin_send || resp_send;
    always_comb begin
        out_data = '0;
        if (fin_send)
            out_data = RW'({(state == S_SEND_FB) ? INFO_FIN_BC : INFO_FIN_COMP, 16'h0, 16'(PE_ID)});
        else if (resp_send)
            out_data = RW'({INFO_READ, resp_addr, resp_data});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_credit <= CNT_W'(FIFO_DEPTH);
        else if (out_data_valid && !downstream_credit)
            out_credit <= out_credit - CNT_W'(1);
        else if (!out_data_valid && downstream_credit)
            out_credit <= out_credit + CNT_W'(1);
    end

    // ---------------- READ path ----------------
`ifdef PE_NODE_READ_EN
    logic        read_local, rd_pend;
    logic [15:0] rd_addr_q;

    assign read_local = (head_info == INFO_READ) && for_me;
    // A READ waits until the single response slot (including a capture in flight) is free.
    assign pop        = !fifo_empty && !(read_local && (resp_valid || rd_pend));
    assign rf_rd_en   = pop && read_local;
    assign rf_rd_addr = rf_rd_en ? head_addr[9:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            rd_addr_q  <= '0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            rd_pend <= rf_rd_en;
            if (rf_rd_en) rd_addr_q <= head_addr;
            if (rd_pend) begin
                resp_valid <= 1'b1;
                resp_addr  <= rd_addr_q;
                resp_data  <= rf_rd_data;
            end else if (resp_send) begin
                resp_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rf_rd_data;
    assign pop        = !fifo_empty;
    assign rf_rd_en   = 1'b0;
    assign rf_rd_addr = '0;
    assign resp_valid = 1'b0;
    assign resp_addr  = '0;
    assign resp_data  = '0;
`endif

    // ---------------- CONFIG path and credit return ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upstream_credit <= 1'b0;
            rf_wr_en        <= 1'b0;
            rf_wr_addr      <= '0;
            rf_wr_data      <= '0;
            layer_no        <= '0;
        end else begin
            upstream_credit <= pop;
            rf_wr_en        <= 1'b0;
            if (pop && head_info == INFO_CONFIG) begin
                if (addr_zero) begin
                    layer_no <= head_data[`PeLayerNoBus];
                end else if (for_me) begin
                    rf_wr_en   <= 1'b1;
                    rf_wr_addr <= head_addr[9:0];
                    rf_wr_data <= head_data;
                end
            end
        end
    end

    // ---------------- layer FSM ----------------
    assign last_idx   = (layer_no == '0) ? '0 : layer_no - LNW'(1);
    assign comp_layer = layer_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            layer_idx   <= '0;
            bcast_start <= 1'b0;
            comp_start  <= 1'b0;
            done        <= 1'b0;
        end else begin
            bcast_start <= 1'b0;
            comp_start  <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: if (pop && head_info == INFO_CALC) begin
                    layer_idx   <= '0;
                    state       <= S_BCAST;
                    bcast_start <= 1'b1;
                end
                S_BCAST:   if (bcast_done) state <= S_SEND_FB;
                S_SEND_FB: if (fin_send)   state <= S_WAIT_FB;
                S_WAIT_FB: if (pop && head_info == INFO_FIN_BC) begin
                    state      <= S_COMP;
                    comp_start <= 1'b1;
                end
                S_COMP:    if (comp_done)  state <= S_SEND_FC;
                S_SEND_FC: if (fin_send)   state <= S_WAIT_FC;
                S_WAIT_FC: if (pop && head_info == INFO_FIN_COMP) begin
                    if (layer_idx == last_idx) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        layer_idx   <= layer_idx + LNW'(1);
                        state       <= S_BCAST;
                        bcast_start <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_node_controller.sv
// Scoreboard bench for pe_node_controller: random CONFIG/READ traffic plus directed layer runs and credit stall.
`timescale 1ns/1ps
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef PeLayerNoBus
`define PeLayerNoBus 3:0
`endif

module tb_pe_node_controller;
    localparam int PE = 5;
    localparam int DEPTH = 4;
    localparam int RW = `ROUTER_WIDTH;
    localparam logic [3:0] I_CONFIG = 4'd1, I_READ = 4'd2, I_CALC = 4'd3, I_FB = 4'd4, I_FC = 4'd5;

    logic clk, rst, in_data_valid, upstream_credit, out_data_valid, downstream_credit;
    logic [RW-1:0] in_data, out_data;
    logic rf_wr_en, rf_rd_en, bcast_start, bcast_done, comp_start, comp_done, done;
    logic [9:0] rf_wr_addr, rf_rd_addr;
    logic [15:0] rf_wr_data, rf_rd_data;
    logic [`PeLayerNoBus] comp_layer;
    logic dc_auto, dc_man;

    int tests = 0, fails = 0, cyc = 0;
    int up_cnt = 0, out_cnt = 0, bc_cnt = 0, cs_cnt = 0, done_cnt = 0, wr_cnt = 0, wr_cyc = 0;
    int in_sent = 0, ret_auto = 0, ret_man = 0, last_cap = 0;
    bit hold = 0;

    logic [RW-1:0] exp_out[$];
    logic [25:0]   exp_wr[$];
    int            exp_ev[$];

    assign downstream_credit = dc_auto | dc_man;

    pe_node_controller #(.PE_ID(PE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data_valid(in_data_valid), .in_data(in_data),
        .upstream_credit(upstream_credit), .out_data_valid(out_data_valid), .out_data(out_data),
        .downstream_credit(downstream_credit), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .bcast_start(bcast_start), .bcast_done(bcast_done), .comp_start(comp_start),
        .comp_layer(comp_layer), .comp_done(comp_done), .done(done)
    );

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [15:0] rf_val(input logic [9:0] a);
        return (a == 10'h007) ? 16'h1234 : (16'h5A00 ^ {a, 6'h2B});
    endfunction

    // Register file model: read data appears the cycle after the request.
    initial begin
        rf_rd_data = '0;
        forever begin @(posedge clk); if (rf_rd_en) rf_rd_data <= rf_val(rf_rd_addr); end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (upstream_credit) up_cnt++;
            if (rf_wr_en) begin
                wr_cnt++; wr_cyc = cyc;
                check("rf_wr", {38'h0, rf_wr_addr, rf_wr_data},
                      exp_wr.size() > 0 ? {38'h0, exp_wr.pop_front()} : 64'hFFFF_FFFF_FFFF_FFFF);
            end
`ifndef PE_NODE_READ_EN
            check("rf_rd_en_off", rf_rd_en, 0);
`endif
            if (out_data_valid) begin
                out_cnt++;
                check("out_pkt", 64'(out_data),
                      exp_out.size() > 0 ? 64'(exp_out.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF);
            end
            if (bcast_start || comp_start || done) begin
                int got;
                got = done ? 300 : comp_start ? 200 + int'(comp_layer) : 100;
                if (bcast_start) bc_cnt++;
                if (comp_start) cs_cnt++;
                if (done) done_cnt++;
                check("ctrl_event", got, exp_ev.size() > 0 ? exp_ev.pop_front() : -1);
            end
        end
    end

    // Router-side credit return for every packet the DUT sends, unless held.
    initial begin
        dc_auto = 0;
        forever begin
            @(posedge clk); #1;
            if (!hold && (out_cnt - ret_auto - ret_man) > 0 && $urandom_range(0, 1) == 1) begin
                dc_auto = 1; ret_auto++;
            end else dc_auto = 0;
        end
    end

    function automatic int cnt_of(input int which);
        case (which)
            0: return out_cnt;
            1: return bc_cnt;
            2: return cs_cnt;
            3: return done_cnt;
            4: return wr_cnt;
            default: return up_cnt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input string name);
        int t = 0;
        while (cnt_of(which) < target && t < 500) begin @(posedge clk); #1; t++; end
        check(name, cnt_of(which) >= target, 1);
    endtask

    task automatic send_pkt(input logic [3:0] info, input logic [15:0] addr, input logic [15:0] data);
        int t = 0;
        while (in_sent - up_cnt >= DEPTH && t < 300) begin @(posedge clk); #1; t++; end
        if (t >= 300) check("upstream_credit_timeout", t, 0);
        in_data_valid = 1;
        in_data = RW'({info, addr, data});
        @(posedge clk); #1;
        last_cap = cyc;
        in_data_valid = 0;
        in_sent++;
    endtask

    task automatic pulse(input int which);
        if (which == 0) bcast_done = 1; else comp_done = 1;
        @(posedge clk); #1;
        bcast_done = 0; comp_done = 0;
    endtask

    task automatic push_fin(input logic [3:0] info);
        exp_out.push_back(RW'({info, 16'h0, 16'(PE)}));
    endtask

    task automatic run_calc(input int nl, input bit stall_last);
        int b0, c0, o0, d0;
        for (int l = 0; l < nl; l++) begin
            exp_ev.push_back(100); push_fin(I_FB);
            exp_ev.push_back(200 + l); push_fin(I_FC);
        end
        exp_ev.push_back(300);
        b0 = bc_cnt; c0 = cs_cnt; o0 = out_cnt; d0 = done_cnt;
        send_pkt(I_CALC, 16'h0, 16'h0);
        for (int l = 0; l < nl; l++) begin
            wait_for(1, b0 + l + 1, "bcast_start");
            pulse(1);
            pulse(0);
            if (stall_last && l == nl - 1) begin
                repeat (6) @(posedge clk);
                #1;
                check("stall_out_cnt", out_cnt, o0 + 2 * l);
                check("stall_valid", out_data_valid, 0);
                @(posedge clk); #1; dc_man = 1; ret_man++;
                @(posedge clk); #1; dc_man = 0;
                check("fb_after_credit", out_data_valid, 1);
                hold = 0;
            end
            wait_for(0, o0 + 2 * l + 1, "fb_sent");
            pulse(0);
            send_pkt(I_FC, 16'h0, 16'h0);
            send_pkt(I_FB, 16'h0, 16'h0);
            wait_for(2, c0 + l + 1, "comp_start");
            pulse(0);
            pulse(1);
            wait_for(0, o0 + 2 * l + 2, "fc_sent");
            send_pkt(I_FC, 16'h0, 16'h0);
        end
        wait_for(3, d0 + 1, "done");
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            int kind;
            logic [5:0] tgt;
            logic [9:0] idx;
            logic [15:0] data;
            logic [3:0] info;
            kind = $urandom_range(0, 9);
            tgt  = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63))
                 : ($urandom_range(0, 1) == 1) ? 6'(PE) : 6'd6;
            idx  = 10'($urandom_range(1, 1023));
            data = 16'($urandom);
            if (kind < 5)      info = I_CONFIG;
            else if (kind < 8) info = I_READ;
            else if (kind < 9) info = ($urandom_range(0, 1) == 1) ? I_FB : I_FC;
            else               info = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(6, 15));
            if (info == I_CONFIG && tgt == 6'(PE)) exp_wr.push_back({idx, data});
`ifdef PE_NODE_READ_EN
            if (info == I_READ && tgt == 6'(PE)) exp_out.push_back(RW'({I_READ, tgt, idx, rf_val(idx)}));
`endif
            send_pkt(info, {tgt, idx}, data);
        end
    endtask

    initial begin
        int u0, w0, t;
        rst = 1; in_data_valid = 0; in_data = '0; bcast_done = 0; comp_done = 0; dc_man = 0;
        repeat (3) @(negedge clk);
        check("rst_upstream_credit", upstream_credit, 0);
        check("rst_out_valid", out_data_valid, 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_rf_wr_en", rf_wr_en, 0);
        check("rst_rf_rd_en", rf_rd_en, 0);
        check("rst_ctrl", {bcast_start, comp_start, done}, 0);
        check("rst_comp_layer", comp_layer, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        // Write to this PE: one rf write one cycle after the pop, one credit back.
        u0 = up_cnt; w0 = wr_cnt;
        exp_wr.push_back({10'h003, 16'hBEEF});
        send_pkt(I_CONFIG, 16'h1403, 16'hBEEF);
        wait_for(4, w0 + 1, "cfg_write_seen");
        check("cfg_write_latency", wr_cyc - last_cap, 1);
        repeat (3) @(posedge clk);
        #1;
        check("cfg_credit_pulse", up_cnt - u0, 1);

        // Write to another PE: dropped but credited.
        send_pkt(I_CONFIG, 16'h1803, 16'h5555);
        repeat (3) @(posedge clk);
        #1;
        check("other_pe_credit", up_cnt - u0, 2);
        check("other_pe_no_write", wr_cnt - w0, 1);

        // READ to this PE.
`ifdef PE_NODE_READ_EN
        exp_out.push_back(RW'({I_READ, 16'h1407, 16'h1234}));
`endif
        send_pkt(I_READ, 16'h1407, 16'h0);
        repeat (6) @(posedge clk);
        #1;
        check("read_credit", up_cnt - u0, 3);

        run_random(60);

        // layer_no = 2, then layer_no = 0 (one layer).
        send_pkt(I_CONFIG, 16'h0000, 16'h0002);
        run_calc(2, 0);
        send_pkt(I_CONFIG, 16'h0000, 16'h0000);
        run_calc(1, 0);

        // Credit stall: all credits back, then hold; 4 FIN packets drain the DUT credit.
        t = 0;
        while ((out_cnt - ret_auto - ret_man) > 0 && t < 200) begin @(posedge clk); #1; t++; end
        check("credits_returned", out_cnt - ret_auto - ret_man, 0);
        hold = 1;
        send_pkt(I_CONFIG, 16'h0000, 16'h0003);
        run_calc(3, 1);

        run_random(30);

        t = 0;
        while ((in_sent != up_cnt || exp_wr.size() > 0 || exp_out.size() > 0) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        check("all_upstream_credits", up_cnt, in_sent);
        check("exp_wr_left", exp_wr.size(), 0);
        check("exp_out_left", exp_out.size(), 0);
        check("exp_ev_left", exp_ev.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_node_controller.md
PE_NODE_CONTROLLER -- requirements
Module: pe_node_controller

Interface
REQ-001 SHALL have parameter PE_ID, default 0, meaning this PE's index (0..63) on the quadtree.
REQ-002 SHALL have parameter FIFO_DEPTH, default `TOT_FIFO_DEPTH, meaning input FIFO depth and initial output credit count (power of 2).
REQ-003 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data_valid  in  1  router LOCAL port packet valid.
- in_data  in  `ROUTER_WIDTH  packet: [35:32] info, [31:16] addr, [15:0] data.
- upstream_credit  out  1  one-cycle credit return per consumed packet.
- out_data_valid  out  1  packet to router valid.
- out_data  out  `ROUTER_WIDTH  packet to router.
- downstream_credit  in  1  credit returned by router.
- rf_wr_en / rf_wr_addr / rf_wr_data  out  1/10/16  local register file write.
- rf_rd_en / rf_rd_addr  out  1/10  local register file read request.
- rf_rd_data  in  16  read data, valid exactly 1 cycle after rf_rd_en.
- bcast_start  out  1  one-cycle pulse starting activation broadcast.
- bcast_done  in  1  one-cycle pulse, broadcast complete.
- comp_start  out  1  one-cycle pulse starting layer computation.
- comp_layer  out  `PeLayerNoBus  current layer index, stable while computing.
- comp_done  in  1  one-cycle pulse, computation complete.
- done  out  1  one-cycle pulse after final layer completes.

Function
REQ-004 Incoming packets SHALL be written to an input FIFO of FIFO_DEPTH; each pop SHALL assert upstream_credit the following cycle (registered, 1 cycle).
REQ-005 Addressing: addr[15:10] = target PE, addr[9:0] = local index; addr==0 is broadcast to all PEs.
REQ-006 CONFIG, addr==0: SHALL load layer_no <= data[`PeLayerNoBus]; no rf write.
REQ-007 CONFIG, addr!=0, addr[15:10]==PE_ID: SHALL pulse rf_wr_en 1 cycle after pop with addr[9:0], data; other PE IDs popped and dropped.
REQ-008 READ to this PE: SHALL pulse rf_rd_en on pop; next cycle capture rf_rd_data into a 1-entry response register {READ, original addr, data}; READ SHALL NOT pop while response register is full.
REQ-009 CALC in IDLE: reset layer_idx to 0, go to BCAST; CALC outside IDLE popped and ignored.
REQ-010 FSM states: IDLE, BCAST, SEND_FB, WAIT_FB, COMP, SEND_FC, WAIT_FC.
- BCAST: bcast_start pulses on entry cycle; bcast_done -> SEND_FB.
- SEND_FB: send {FIN_BROADCAST, 0, PE_ID} when credit available -> WAIT_FB.
- WAIT_FB: popped FIN_BROADCAST -> COMP (comp_start pulses on entry).
- COMP: comp_done -> SEND_FC; SEND_FC sends {FIN_COMP, 0, PE_ID} -> WAIT_FC.
- WAIT_FC: popped FIN_COMP; if layer_idx==layer_no-1 -> IDLE and done pulses next cycle, else layer_idx+1 -> BCAST.
REQ-011 FIN_BROADCAST/FIN_COMP received in any other state SHALL be popped and ignored; unknown info codes popped and ignored.
REQ-012 Output credit counter SHALL init to FIFO_DEPTH, -1 per sent packet, +1 per downstream_credit, both same cycle = hold; no send when 0.
REQ-013 At most one packet sent per cycle; FIN packets SHALL win over pending read response; out_data_valid combinational from state/credit.
REQ-014 layer_no==0 SHALL be treated as 1 layer; layer_idx SHALL wrap naturally in `PeLayerNoBus width.
REQ-015 bcast_done/comp_done outside BCAST/COMP SHALL be ignored.

Reset
REQ-016 On rst: state IDLE, layer_no 0, layer_idx 0, FIFO empty, response register empty, credit count FIFO_DEPTH, all outputs 0; rst mid-operation abandons any in-flight transaction without sending.

Configuration
REQ-017 Macro PE_NODE_READ_EN: defined -> READ behaviour per REQ-008; undefined -> no response register, READ packets popped with credit returned, rf_rd_en held 0, no response sent.

Verification
REQ-018 PE_ID=5: CONFIG addr=0x1403 data=0xBEEF -> rf_wr_en 1 cycle, addr 0x003, data 0xBEEF; upstream_credit 1 pulse.
REQ-019 CONFIG addr=0x1803 (PE 6) -> no rf write, credit returned.
REQ-020 READ addr=0x1407, rf_rd_data=0x1234 -> out packet {READ, 0x1407, 0x1234}; with macro undefined -> no out packet.
REQ-021 layer_no=2, CALC -> bcast_start, FB sent data=5, FIN_BROADCAST in -> comp_start comp_layer=0, FC sent, FIN_COMP in -> second layer comp_layer=1 -> done pulse, IDLE.
REQ-022 downstream_credit withheld, FIFO_DEPTH packets sent -> SEND_FB stalls; one credit returned -> FB sent next cycle.
